rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
Parametrised successor to the core's fixed 7-input round-robin FIFO arbiter. It merges N first-word-fall-through source FIFOs (RX, timestamp, TLU, ...) into one 32-bit-class stream towards the SiTCP/USB output FIFO. On top of round-robin it adds:
- a runtime channel enable mask;
- a fixed-priority mode;
- a per-grant burst limit;
- packet locking via HOLD_REQ;
- a registered channel-ID output.

Parameters:
N, 8, number of source channels (2..32)
W, 32, data word width
BURST_W, 8, width of burst-limit register/counter
ID_W, 5, width of GRANT_ID (must satisfy 2**ID_W >= N)

Ports:
CLK  in  1  single clock; all logic rising-edge
RST_N  in  1  reset, asynchronous assert, active-low
WRITE_REQ  in  N  per-channel not-empty (~FIFO_EMPTY)
HOLD_REQ  in  N  per-channel lock request; keeps grant while set
DATA_IN  in  N*W  concatenated FWFT heads; channel i at [i*W +: W]
READ_GRANT  out  N  one-hot pop strobe to source FIFO i
EN_MASK  in  N  channel enable; 0 = never newly granted
MODE  in  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
BURST_MAX  in  BURST_W  max words per grant; 0 = unlimited
READY_OUT  in  1  sink can accept a word on the next cycle
WRITE_OUT  out  1  registered write strobe to sink
DATA_OUT  out  W  registered word, valid while WRITE_OUT=1
GRANT_ID  out  ID_W  source channel of DATA_OUT, valid with WRITE_OUT
BUSY  out  1  1 while in STREAM state

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, rr_ptr=0, cur=0, burst_cnt=0;
  - WRITE_OUT=0, DATA_OUT=0, GRANT_ID=0, BUSY=0;
  - READ_GRANT=0 (combinational, forced by state).
  - Reset mid-stream discards the in-flight registered word; no pop strobe may appear in the reset cycle.
- Eligible vector: E = WRITE_REQ & EN_MASK.
- FSM, IDLE:
  - if E != 0, select channel sel; cur<=sel, burst_cnt<=0, go STREAM.
  - MODE=0: sel = first set bit of E searching upward from rr_ptr, wrapping N-1 -> 0.
  - MODE=1: sel = lowest set bit of E.
  - The IDLE cycle is a one-cycle arbitration bubble; no pop in IDLE.
- FSM, STREAM:
  - pop = WRITE_REQ[cur] & READY_OUT & ~limit_hit, where limit_hit = (BURST_MAX!=0) & (burst_cnt==BURST_MAX).
  - READ_GRANT[cur] = pop (combinational, same cycle); all other bits 0.
  - On pop: DATA_OUT<=DATA_IN[cur], GRANT_ID<=cur, WRITE_OUT<=1 next cycle. Latency 1 cycle; otherwise WRITE_OUT<=0.
  - burst_cnt increments on pop and saturates at 2**BURST_W-1.
  - Leave STREAM to IDLE when HOLD_REQ[cur]=0 and any of:
    - WRITE_REQ[cur]=0;
    - limit_hit, or pop making burst_cnt+1==BURST_MAX;
    - EN_MASK[cur]=0.
  - On leaving, rr_ptr <= (cur+1) mod N.
  - HOLD_REQ[cur]=1 keeps the grant even when the channel is empty, disabled or at its burst limit. Pops still require WRITE_REQ[cur] and ~limit_hit; at the limit the burst stalls until HOLD drops.
- READY_OUT=0 in STREAM: no pop and the state holds. The grant is not lost.
- Simultaneous requests: MODE=0 gives each eligible channel exactly one grant per rotation. MODE=1 may starve higher indices (intended).
- MODE, EN_MASK and BURST_MAX are sampled live:
  - a change takes effect at the next IDLE decision;
  - an EN_MASK drop also ends the current grant, per the exit rules above.
- N not a power of two: rr_ptr wraps at N, never at 2**ID_W.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, STREAM);
  - the priority-search function (first set bit from a start index, with wrap);
  - the constant ID_W derivation helper (clog2).
- One sub-module, rr_pick, is natural: a combinational N-bit rotate + priority encoder returning {found, index}. It is instantiated once and fed either rr_ptr or 0 as the start index depending on MODE.

Test Plan:
- Reset/idle: N=4, all FIFOs empty. Hold RST_N low then release -> WRITE_OUT=0, READ_GRANT=0, BUSY=0 for 20 cycles. Asserting RST_N low mid-stream clears WRITE_OUT in the same cycle.
- Round-robin fairness: MODE=0, BURST_MAX=1, channels 0, 2, 3 each hold 3 words -> GRANT_ID sequence 0,2,3,0,2,3,0,2,3, with one bubble cycle between grants.
- Burst limit: MODE=0, BURST_MAX=4. Ch1 has 10 words, ch2 has 2 words -> ch1 x4, ch2 x2, ch1 x4, ch1 x2. BURST_MAX=0 gives ch1 x10 back-to-back, then ch2 x2.
- Hold lock: HOLD_REQ[0]=1, ch0 FIFO runs empty for 5 cycles while ch1 has data -> ch1 is not granted and BUSY stays 1. When ch0 refills, its words continue. After HOLD drops and ch0 empties, ch1 is granted.
- Backpressure: READY_OUT toggles 1,0,0,1 during a ch3 burst of 6 words -> pops occur only in READY_OUT=1 cycles. All 6 words arrive in order with GRANT_ID=3, none duplicated or dropped.
- Fixed priority + mask: MODE=1, EN_MASK=4'b1110, all channels non-empty -> ch0 is never granted and ch1 is drained first. Clearing EN_MASK[1] mid-burst ends the grant and moves to ch2.

Source files
------------

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the FSM state enum, the wrap-around priority search and the ID width helper.
package rr_burst_arbiter_pkg;

    typedef enum logic {StIdle, StStream} state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // Smallest GRANT_ID width able to name every channel.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of vec[n-1:0], searching upward from start and wrapping n-1 -> 0.
    function automatic pick_t first_set(input logic [31:0] vec, input int unsigned start,
                                        input int unsigned n);
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < n) begin
                j = start + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.found && vec[j[4:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[4:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational rotate + priority encoder: first requesting channel at or after start_i.
module rr_pick
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned ID_W = 5
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] start_i,
    output logic            found_o,
    output logic [ID_W-1:0] index_o
);

    logic [31:0] req_ext;
    pick_t       res;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req_i;
        res              = first_set(req_ext, 32'(start_i), N);
        found_o          = res.found;
        index_o          = ID_W'(res.idx);
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-channel FWFT FIFO merger: round-robin or fixed priority, burst limit, hold lock,
// registered data/ID output towards a single sink FIFO.
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = 32,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned ID_W    = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [N-1:0]       WRITE_REQ,
    input  logic [N-1:0]       HOLD_REQ,
    input  logic [N*W-1:0]     DATA_IN,
    output logic [N-1:0]       READ_GRANT,
    input  logic [N-1:0]       EN_MASK,
    input  logic               MODE,
    input  logic [BURST_W-1:0] BURST_MAX,
    input  logic               READY_OUT,
    output logic               WRITE_OUT,
    output logic [W-1:0]       DATA_OUT,
    output logic [ID_W-1:0]    GRANT_ID,
    output logic               BUSY
);

    if (ID_W < id_width(N)) begin : g_id_w_check
        $error("ID_W too small for N");
    end

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    cur_q, cur_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               write_q;
    logic [W-1:0]       data_q;
    logic [ID_W-1:0]    grant_id_q;

    logic [N-1:0]    eligible;
    logic [ID_W-1:0] pick_start;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    logic         cur_req, cur_hold, cur_en;
    logic [W-1:0] cur_data;
    logic         limit_hit, last_of_burst, pop, leave;

    assign eligible   = WRITE_REQ & EN_MASK;
    assign pick_start = MODE ? '0 : rr_ptr_q;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (eligible),
        .start_i (pick_start),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    // Mux the granted channel's controls and FWFT head.
    always_comb begin
        cur_req  = 1'b0;
        cur_hold = 1'b0;
        cur_en   = 1'b0;
        cur_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cur_q == ID_W'(i)) begin
                cur_req  = WRITE_REQ[i];
                cur_hold = HOLD_REQ[i];
                cur_en   = EN_MASK[i];
                cur_data = DATA_IN[i*W +: W];
            end
        end
    end

    assign limit_hit     = (BURST_MAX != '0) && (burst_cnt_q == BURST_MAX);
    assign pop           = (state_q == StStream) && cur_req && READY_OUT && !limit_hit;
    assign last_of_burst = pop && (({1'b0, burst_cnt_q} + 1'b1) == {1'b0, BURST_MAX});
    assign leave         = !cur_hold && (!cur_req || limit_hit || last_of_burst || !cur_en);

    always_comb begin
        READ_GRANT = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pop && (cur_q == ID_W'(i))) begin
                READ_GRANT[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    cur_d       = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = StStream;
                end
            end
            StStream: begin
                if (pop && (burst_cnt_q != '1)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if (leave) begin
                    state_d  = StIdle;
                    // Wrap at N, not at the ID field width.
                    rr_ptr_d = (cur_q == ID_W'(N - 1)) ? '0 : cur_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            burst_cnt_q <= '0;
            write_q     <= 1'b0;
            data_q      <= '0;
            grant_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            write_q     <= pop;
            if (pop) begin
                data_q     <= cur_data;
                grant_id_q <= cur_q;
            end
        end
    end

    assign WRITE_OUT = write_q;
    assign DATA_OUT  = data_q;
    assign GRANT_ID  = grant_id_q;
    assign BUSY      = (state_q == StStream);

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: queue-based source FIFOs, a per-cycle behavioural arbiter model,
// directed scenarios with hand-written grant orders, then a randomized soak.
module tb_rr_burst_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int BW  = 8;
    localparam int IDW = 3;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   WRITE_REQ = '0;
    logic [N-1:0]   HOLD_REQ = '0;
    logic [N*W-1:0] DATA_IN = '0;
    logic [N-1:0]   READ_GRANT;
    logic [N-1:0]   EN_MASK = '1;
    logic           MODE = 1'b0;
    logic [BW-1:0]  BURST_MAX = '0;
    logic           READY_OUT = 1'b1;
    logic           WRITE_OUT;
    logic [W-1:0]   DATA_OUT;
    logic [IDW-1:0] GRANT_ID;
    logic           BUSY;

    rr_burst_arbiter #(
        .N       (N),
        .W       (W),
        .BURST_W (BW),
        .ID_W    (IDW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .WRITE_REQ  (WRITE_REQ),
        .HOLD_REQ   (HOLD_REQ),
        .DATA_IN    (DATA_IN),
        .READ_GRANT (READ_GRANT),
        .EN_MASK    (EN_MASK),
        .MODE       (MODE),
        .BURST_MAX  (BURST_MAX),
        .READY_OUT  (READY_OUT),
        .WRITE_OUT  (WRITE_OUT),
        .DATA_OUT   (DATA_OUT),
        .GRANT_ID   (GRANT_ID),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef logic [W-1:0] word_q_t[$];
    word_q_t fifo [N];
    int      push_seq [N];
    int      exp_seq [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the grant, words sent in this grant, and whose turn is next.
    bit           m_busy;
    int           m_ch, m_cnt, m_ptr;
    bit           m_wr;
    logic [W-1:0] m_data;
    int           m_id;
    logic [N-1:0] m_grant;
    bit           m_pop, m_leave;
    int           m_sel;
    logic [W-1:0] m_pop_data;
    logic [N-1:0] grant_seen;

    int           log_id[$];
    logic [W-1:0] log_data[$];
    int           exp_id[$];
    logic [W-1:0] exp_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ch = 0; m_cnt = 0; m_ptr = 0;
        m_wr = 0; m_data = '0; m_id = 0;
    endtask

    task automatic model_comb();
        int  burst, start, c;
        bit  lim;
        burst   = int'(BURST_MAX);
        m_grant = '0;
        m_pop   = 0;
        m_leave = 0;
        m_sel   = -1;
        if (m_busy) begin
            lim        = (burst != 0) && (m_cnt == burst);
            m_pop      = WRITE_REQ[m_ch] && READY_OUT && !lim;
            m_pop_data = DATA_IN[m_ch*W +: W];
            if (m_pop) m_grant[m_ch] = 1'b1;
            m_leave = !HOLD_REQ[m_ch] && (!WRITE_REQ[m_ch] || lim ||
                      (m_pop && (m_cnt + 1 == burst)) || !EN_MASK[m_ch]);
        end else begin
            start = MODE ? 0 : m_ptr;
            for (int k = 0; k < N; k++) begin
                c = (start + k) % N;
                if (m_sel < 0 && WRITE_REQ[c] && EN_MASK[c]) m_sel = c;
            end
        end
    endtask

    task automatic model_seq();
        m_wr = m_pop;
        if (m_pop) begin
            m_data = m_pop_data;
            m_id   = m_ch;
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (m_busy && m_leave) begin
            m_busy = 0;
            m_ptr  = (m_ch + 1) % N;
        end else if (!m_busy && m_sel >= 0) begin
            m_busy = 1;
            m_ch   = m_sel;
            m_cnt  = 0;
        end
    endtask

    task automatic compare();
        chk("read_grant", 64'(READ_GRANT), 64'(m_grant));
        chk("busy", 64'(BUSY), 64'(m_busy));
        chk("write_out", 64'(WRITE_OUT), 64'(m_wr));
        chk("data_out", 64'(DATA_OUT), 64'(m_data));
        chk("grant_id", 64'(GRANT_ID), 64'(m_id));
    endtask

    task automatic cycle();
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            WRITE_REQ[i]      = (fifo[i].size() != 0);
            DATA_IN[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
        #1;
        model_comb();
        compare();
        if (WRITE_OUT) begin
            log_id.push_back(int'(GRANT_ID));
            log_data.push_back(DATA_OUT);
        end
        grant_seen = READ_GRANT;
        @(posedge CLK);
        #1;
        model_seq();
        for (int i = 0; i < N; i++) begin
            if (grant_seen[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            fifo[ch].push_back({8'(ch), 24'(push_seq[ch])});
            push_seq[ch]++;
        end
    endtask

    task automatic exp_run(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            exp_id.push_back(ch);
            exp_data.push_back({8'(ch), 24'(exp_seq[ch])});
            exp_seq[ch]++;
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = !m_busy && !m_wr;
        for (int i = 0; i < N; i++) if (fifo[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic drain(input string name, input int max);
        for (int c = 0; c < max; c++) begin
            if (all_idle()) return;
            cycle();
        end
        n_checks++;
        if (!all_idle()) begin
            n_fail++;
            $display("FAIL %s: not drained after %0d cycles, got busy expected idle", name, max);
        end
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 64'(log_id.size()), 64'(exp_id.size()));
        for (int i = 0; i < log_id.size() && i < exp_id.size(); i++) begin
            chk({name, "_id"}, 64'(log_id[i]), 64'(exp_id[i]));
            chk({name, "_data"}, 64'(log_data[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        WRITE_REQ = '0;
        DATA_IN   = '0;
        HOLD_REQ  = '0;
        EN_MASK   = '1;
        MODE      = 1'b0;
        BURST_MAX = '0;
        READY_OUT = 1'b1;
        for (int i = 0; i < N; i++) begin
            fifo[i].delete();
            push_seq[i] = 0;
            exp_seq[i]  = 0;
        end
        log_id.delete(); log_data.delete(); exp_id.delete(); exp_data.delete();
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [3:0] pat;

        // Reset values while RST_N is held low.
        #12;
        chk("rst_write_out", 64'(WRITE_OUT), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_read_grant", 64'(READ_GRANT), 64'd0);
        chk("rst_data_out", 64'(DATA_OUT), 64'd0);
        chk("rst_grant_id", 64'(GRANT_ID), 64'd0);

        do_reset();
        repeat (20) cycle();
        chk("idle_busy", 64'(BUSY), 64'd0);

        // Round-robin fairness, one word per grant.
        do_reset();
        BURST_MAX = 8'd1;
        push(0, 3); push(2, 3); push(3, 3);
        for (int r = 0; r < 3; r++) begin
            exp_run(0, 1); exp_run(2, 1); exp_run(3, 1);
        end
        drain("rr", 100);
        check_log("rr");

        // Burst limit of 4.
        do_reset();
        BURST_MAX = 8'd4;
        push(1, 10); push(2, 2);
        exp_run(1, 4); exp_run(2, 2); exp_run(1, 4); exp_run(1, 2);
        drain("burst4", 200);
        check_log("burst4");

        // Unlimited burst.
        do_reset();
        push(1, 10); push(2, 2);
        exp_run(1, 10); exp_run(2, 2);
        drain("burst0", 200);
        check_log("burst0");

        // Hold lock keeps ch0 granted while its FIFO is empty.
        do_reset();
        HOLD_REQ = 4'b0001;
        push(0, 2); push(1, 3);
        repeat (8) cycle();
        chk("hold_busy", 64'(BUSY), 64'd1);
        cnt = 0;
        foreach (log_id[i]) if (log_id[i] == 1) cnt++;
        chk("hold_no_ch1", 64'(cnt), 64'd0);
        push(0, 2);
        repeat (3) cycle();
        HOLD_REQ = '0;
        exp_run(0, 4); exp_run(1, 3);
        drain("hold", 100);
        check_log("hold");

        // Backpressure pattern 1,0,0,1.
        do_reset();
        push(3, 6);
        pat = 4'b1001;
        for (int c = 0; c < 80 && !all_idle(); c++) begin
            READY_OUT = pat[c % 4];
            cycle();
            chk("bp_pop_needs_ready", 64'(grant_seen & ~{N{READY_OUT}}), 64'd0);
        end
        READY_OUT = 1'b1;
        exp_run(3, 6);
        check_log("bp");

        // Fixed priority with ch0 masked; dropping EN_MASK[1] ends ch1's grant.
        do_reset();
        MODE    = 1'b1;
        EN_MASK = 4'b1110;
        for (int i = 0; i < N; i++) push(i, 5);
        repeat (4) cycle();
        EN_MASK = 4'b1100;
        repeat (30) cycle();
        exp_run(1, 4); exp_run(2, 5); exp_run(3, 5);
        check_log("prio");
        chk("prio_ch0_left", 64'(fifo[0].size()), 64'd5);

        // Asynchronous reset mid-stream.
        do_reset();
        push(0, 5);
        repeat (3) cycle();
        chk("pre_rst_write", 64'(WRITE_OUT), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_write", 64'(WRITE_OUT), 64'd0);
        chk("mid_rst_grant", 64'(READ_GRANT), 64'd0);
        chk("mid_rst_busy", 64'(BUSY), 64'd0);

        // Randomized soak against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (fifo[i].size() < 6 && $urandom_range(0, 2) == 0) push(i, 1);
            end
            if ($urandom_range(0, 19) == 0) EN_MASK = N'($urandom);
            if ($urandom_range(0, 29) == 0) MODE = ~MODE;
            if ($urandom_range(0, 9) == 0) BURST_MAX = BW'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0)
                HOLD_REQ = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            READY_OUT = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
